uart_host_bridge: RTL and testbench
===================================

// Module: uart_host_bridge
// PURPOSE
//  Bus-side initiator for uart_top. Drives writes0/reads10/in_port, samples uart_ds/uart_int.
//  Moves bytes between two internal FIFOs and the UART register interface so user logic only
//  sees valid/ready byte streams. Sits between fabric logic and uart_top; replaces the CPU.
// PARAMETERS
//  DEPTH       16   entries per FIFO (power of 2, >=2)
//  POLL_CYCLES 255  idle cycles between forced status polls (0 = poll every idle cycle)
//  SETTLE      2    wait cycles after each data access before the next status read (>=1)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  tx_data    in   8   byte to transmit
//  tx_valid   in   1   tx_data valid
//  tx_ready   out  1   TX FIFO not full; push when tx_valid&tx_ready
//  rx_data    out  8   received byte (FIFO head)
//  rx_err     out  3   {ovf,ferr,perr} captured with rx_data
//  rx_valid   out  1   RX FIFO not empty
//  rx_ready   in   1   pop when rx_valid&rx_ready
//  uart_ds    in   8   uart_top read data (combinational from reads10)
//  uart_int   in   1   uart_top interrupt pulse
//  reads10    out  2   01=read data (clears rxrdy), 10=read status, 00=none
//  writes0    out  1   one-cycle write strobe to TX engine
//  out_port   out  8   write data, valid only in the writes0 cycle (to uart_top in_port)
//  err_cnt    out  8   saturating error count (see CONFIGURATION)
// BEHAVIOUR
//  Clock clk, reset rst: one clock; reset is synchronous and active-high.
//  Reset: FSM=IDLE, reads10=00, writes0=0, out_port=0, both FIFOs empty, tx_ready=1,
//   rx_valid=0, rx_data/rx_err=0, poll counter=POLL_CYCLES, err_cnt=0.
//  Status byte = {3'b0,ovf,ferr,perr,txrdy,rxrdy}; bit indices from package.
//  FSM: IDLE, RD_STAT, DECIDE, RD_DATA, WR_DATA, SETTLE_W.
//   IDLE   -> RD_STAT if uart_int | tx FIFO non-empty | poll counter==0; else decrement counter.
//   RD_STAT: reads10=10 one cycle; latch uart_ds into stat_q same edge; reload poll counter.
//   DECIDE: rxrdy & RX FIFO not full -> RD_DATA; else txrdy & TX FIFO non-empty -> WR_DATA;
//           else -> IDLE. RX has priority over TX.
//   RD_DATA: reads10=01 one cycle; push {stat_q[ovf,ferr,perr],uart_ds} same edge -> SETTLE_W.
//   WR_DATA: writes0=1, out_port=TX FIFO head one cycle; pop same edge -> SETTLE_W.
//   SETTLE_W: SETTLE cycles, no strobes -> IDLE.
//  Strobes are registered outputs, mutually exclusive, never high two consecutive cycles.
//  Min latency tx push->writes0: 4 cycles (IDLE,RD_STAT,DECIDE,WR_DATA) with txrdy=1.
//  RX FIFO full with rxrdy=1: byte left in UART (no read); UART overflow reported later via ovf.
//  FIFO push and pop same cycle: legal at any fill; full stays full, empty+push shows next cycle.
//  FIFO pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
//  uart_int arriving outside IDLE: not lost, latched in int_pend, cleared on entry to RD_STAT.
//  rst mid-transfer: strobes drop next edge, FIFO contents discarded.
// CONFIGURATION
//  UART_HOST_ERRCNT_EN defined: err_cnt increments (saturate 255) on each RD_DATA whose
//   captured {ovf,ferr,perr}!=0; cleared only by rst.
//  Not defined: err_cnt tied to 8'h00, no counter flops.
// STRUCTURE
//  Package uart_host_pkg: status bit indices (ST_RXRDY=0,ST_TXRDY=1,ST_PERR=2,ST_FERR=3,
//   ST_OVF=4), reads10 codes (RD_NONE,RD_DATA,RD_STAT), FSM state encoding.
//  Sub-module sync_fifo (WIDTH, DEPTH): instanced twice, TX width 8, RX width 11.
// TESTING
//  1 Reset: rst 2 cycles -> all strobes 0, tx_ready=1, rx_valid=0, err_cnt=0.
//  2 TX: push 8'hA5 with model txrdy=1 -> writes0 once, out_port=8'hA5, 4 cycles after push.
//  3 RX: model rxrdy=1 data 8'h3C, uart_int pulse -> reads10=10 then 01; rx_data=3C, rx_err=0.
//  4 Priority: rxrdy=1, txrdy=1, TX FIFO holds 8'h11 -> RD_DATA precedes WR_DATA.
//  5 Full: RX FIFO filled with DEPTH bytes, rx_ready=0, rxrdy=1 -> no reads10=01 issued;
//    pop one -> read resumes; ferr=1 byte -> rx_err=3'b010, err_cnt=1 (with macro), 0 without.
//  6 Reset mid-write: rst during WR_DATA -> writes0=0 next cycle, TX FIFO empty, tx_ready=1.

Source files
------------

// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host bridge: status bit positions,
// reads10 command codes and the bridge FSM state encoding.
// Imported by the bridge top level.
package uart_host_pkg;

  // Bit positions inside the uart_top status byte {3'b0,ovf,ferr,perr,txrdy,rxrdy}
  localparam int ST_RXRDY = 0;
  localparam int ST_TXRDY = 1;
  localparam int ST_PERR  = 2;
  localparam int ST_FERR  = 3;
  localparam int ST_OVF   = 4;

  // reads10 command codes driven towards uart_top
  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_DATA = 2'b01;
  localparam logic [1:0] RD_STAT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_STAT,
    S_DECIDE,
    S_RD_DATA,
    S_WR_DATA,
    S_SETTLE_W
  } state_e;

endpackage

// File: rtl/uart_host_bridge_fifo.sv
// Synchronous FIFO with power-of-two depth; head is presented combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Push while full is accepted only together with a pop; pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | pop_i);
  assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy governs visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_host_bridge.sv
// Bus initiator for uart_top: polls status, drains RX bytes and feeds TX bytes via two FIFOs.
// Latency: tx push to writes0 is at least 4 cycles; each data access is followed by SETTLE idle cycles.
// Backpressure: tx_ready drops when the TX FIFO is full; a full RX FIFO leaves bytes in the UART.
// Optional feature macro: UART_HOST_ERRCNT_EN enables the saturating err_cnt counter.
module uart_host_bridge
  import uart_host_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int POLL_CYCLES = 255,
  parameter int SETTLE      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic [2:0] rx_err,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] uart_ds,
  input  logic       uart_int,
  output logic [1:0] reads10,
  output logic       writes0,
  output logic [7:0] out_port,
  output logic [7:0] err_cnt
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES + 1) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [4:0]      stat_q, stat_d;
  logic            int_pend_q, int_pend_d;
  logic [1:0]      reads10_q, reads10_d;
  logic            writes0_q, writes0_d;
  logic [7:0]      out_port_q, out_port_d;

  logic            tx_full, tx_empty, tx_pop;
  logic [7:0]      tx_head;
  logic            rx_full, rx_empty, rx_push;
  logic [2:0]      stat_err;
  logic [10:0]     rx_head;

  assign stat_err = {stat_q[ST_OVF], stat_q[ST_FERR], stat_q[ST_PERR]};
  assign tx_pop   = (state_q == S_WR_DATA);
  assign rx_push  = (state_q == S_RD_DATA);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (tx_valid & ~tx_full),
    .push_dat_i (tx_data),
    .pop_i      (tx_pop),
    .pop_dat_o  (tx_head),
    .full_o     (tx_full),
    .empty_o    (tx_empty)
  );

  // RX entries carry the error flags seen in the status read that preceded the data read
  sync_fifo #(.WIDTH(11), .DEPTH(DEPTH)) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rx_push),
    .push_dat_i ({stat_err, uart_ds}),
    .pop_i      (rx_valid & rx_ready),
    .pop_dat_o  (rx_head),
    .full_o     (rx_full),
    .empty_o    (rx_empty)
  );

  assign tx_ready = ~tx_full;
  assign rx_valid = ~rx_empty;
  assign {rx_err, rx_data} = rx_head;
  assign reads10  = reads10_q;
  assign writes0  = writes0_q;
  assign out_port = out_port_q;

  // State register plus registered strobes and bookkeeping counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      poll_q     <= PW'(POLL_CYCLES);
      settle_q   <= '0;
      stat_q     <= '0;
      int_pend_q <= 1'b0;
      reads10_q  <= RD_NONE;
      writes0_q  <= 1'b0;
      out_port_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      settle_q   <= settle_d;
      stat_q     <= stat_d;
      int_pend_q <= int_pend_d;
      reads10_q  <= reads10_d;
      writes0_q  <= writes0_d;
      out_port_q <= out_port_d;
    end
  end

  // Next-state logic; strobes are decoded from the next state so they line up with it
  always_comb begin
    state_d    = state_q;
    poll_d     = poll_q;
    settle_d   = settle_q;
    stat_d     = stat_q;
    int_pend_d = int_pend_q | uart_int;
    case (state_q)
      S_IDLE: begin
        if (uart_int | int_pend_q | ~tx_empty | (poll_q == '0)) begin
          state_d    = S_RD_STAT;
          int_pend_d = 1'b0;
        end else begin
          poll_d = poll_q - 1'b1;
        end
      end
      S_RD_STAT: begin
        stat_d  = uart_ds[4:0];
        poll_d  = PW'(POLL_CYCLES);
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (stat_q[ST_RXRDY] & ~rx_full)       state_d = S_RD_DATA;
        else if (stat_q[ST_TXRDY] & ~tx_empty) state_d = S_WR_DATA;
        else                                   state_d = S_IDLE;
      end
      S_RD_DATA, S_WR_DATA: begin
        settle_d = SW'(SETTLE - 1);
        state_d  = S_SETTLE_W;
      end
      S_SETTLE_W: begin
        if (settle_q == '0) state_d = S_IDLE;
        else                settle_d = settle_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    reads10_d  = RD_NONE;
    if (state_d == S_RD_STAT) reads10_d = RD_STAT;
    if (state_d == S_RD_DATA) reads10_d = RD_DATA;
    writes0_d  = (state_d == S_WR_DATA);
    out_port_d = writes0_d ? tx_head : 8'h00;
  end

`ifdef UART_HOST_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Count data reads whose captured status flagged any receive error, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if (rx_push && (stat_err != 3'b000) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_host_bridge.sv
// Randomized scoreboard bench for uart_host_bridge with a behavioural uart_top model.
// Expected TX/RX bytes are queued at stimulus time and popped by an independent monitor.
module tb_uart_host_bridge;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic [2:0] rx_err;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] uart_ds;
  logic       uart_int = 1'b0;
  logic [1:0] reads10;
  logic       writes0;
  logic [7:0] out_port;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues and bookkeeping
  logic [7:0]  tx_exp [$];
  logic [10:0] rx_exp [$];
  logic [10:0] in_q   [$];
  int rd_data_cnt = 0;
  int wr_cnt      = 0;
  int err_exp     = 0;
  int rx_mode     = 0;
  int int_pct     = 75;

  // uart_top model state
  logic       m_rxrdy  = 1'b0;
  logic [7:0] m_rxbyte = 8'h00;
  logic [2:0] m_err    = 3'b000;
  logic       m_txrdy  = 1'b1;
  int         m_txbusy = 0;

  always #5 clk = ~clk;

  uart_host_bridge #(.DEPTH(DEPTH), .POLL_CYCLES(255), .SETTLE(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_err   (rx_err),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .uart_ds  (uart_ds),
    .uart_int (uart_int),
    .reads10  (reads10),
    .writes0  (writes0),
    .out_port (out_port),
    .err_cnt  (err_cnt)
  );

  // Register read port of the modelled UART
  assign uart_ds = (reads10 == 2'b10) ? {3'b000, (m_rxrdy ? m_err : 3'b000), m_txrdy, m_rxrdy} :
                   (reads10 == 2'b01) ? m_rxbyte : 8'h00;

  // Modelled UART: one receive holding register fed from in_q, TX busy for a few cycles per write
  always @(posedge clk) begin
    uart_int <= 1'b0;
    if (rst) begin
      m_rxrdy  <= 1'b0;
      m_txrdy  <= 1'b1;
      m_txbusy <= 0;
    end else begin
      if (reads10 == 2'b01) begin
        m_rxrdy <= 1'b0;
      end else if (!m_rxrdy && in_q.size() != 0) begin
        m_rxbyte <= in_q[0][7:0];
        m_err    <= in_q[0][10:8];
        m_rxrdy  <= 1'b1;
        uart_int <= ($urandom_range(0, 99) < int_pct);
        void'(in_q.pop_front());
      end
      if (writes0) begin
        m_txrdy  <= 1'b0;
        m_txbusy <= $urandom_range(0, 5);
      end else if (!m_txrdy) begin
        if (m_txbusy == 0) m_txrdy <= 1'b1;
        else               m_txbusy <= m_txbusy - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: scoreboard pops plus bus protocol rules, sampled on the falling edge
  initial begin : monitor
    logic [1:0]  h1, h2;
    logic        prev_strobe, cur_strobe;
    logic [7:0]  te;
    logic [10:0] re;
    h1 = 2'b00; h2 = 2'b00; prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      cur_strobe = (writes0 === 1'b1) || (reads10 !== 2'b00 && reads10 !== 2'bxx);
      if (cur_strobe) begin
        chk("strobe_back_to_back", 32'(prev_strobe), 32'(0));
        chk("strobe_exclusive", 32'((writes0 && reads10 != 2'b00) || reads10 == 2'b11), 32'(0));
      end
      if (writes0 === 1'b1) begin
        wr_cnt++;
        chk("wr_txrdy", 32'(m_txrdy), 32'(1));
        chk("wr_after_stat", 32'(h2), 32'(2'b10));
        chk("tx_expected", 32'(tx_exp.size() != 0), 32'(1));
        if (tx_exp.size() != 0) begin
          te = tx_exp.pop_front();
          chk("out_port", 32'(out_port), 32'(te));
        end
      end
      if (reads10 === 2'b01) begin
        rd_data_cnt++;
        chk("rd_rxrdy", 32'(m_rxrdy), 32'(1));
        chk("rd_after_stat", 32'(h2), 32'(2'b10));
      end
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        chk("rx_expected", 32'(rx_exp.size() != 0), 32'(1));
        if (rx_exp.size() != 0) begin
          re = rx_exp.pop_front();
          chk("rx_data", 32'(rx_data), 32'(re[7:0]));
          chk("rx_err", 32'(rx_err), 32'(re[10:8]));
        end
      end
      h2 = h1;
      h1 = reads10;
      prev_strobe = cur_strobe;
    end
  end

  // rx_ready driver, offset after the stimulus process so rx_mode changes are seen deterministically
  initial begin : rx_drv
    rx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rx_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = (($urandom % 4) != 0);
        default: rx_ready = 1'b1;
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic inject_rx(input logic [7:0] d, input logic [2:0] e);
    in_q.push_back({e, d});
    rx_exp.push_back({e, d});
    if (e != 3'b000 && err_exp < 255) err_exp++;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the byte
  task automatic push_tx(input logic [7:0] d);
    int n;
    n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_push_accepted", 32'(tx_ready), 32'(1));
    if (tx_ready) tx_exp.push_back(d);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0) && n < budget) begin
      cyc(1);
      n++;
    end
    chk("drain_done", 32'(tx_exp.size() + rx_exp.size()), 32'(0));
  endtask

  task automatic chk_err_cnt(input string name);
`ifdef UART_HOST_ERRCNT_EN
    chk(name, 32'(err_cnt), 32'(err_exp));
`else
    chk(name, 32'(err_cnt), 32'(0));
`endif
  endtask

  initial begin : stim
    int n, lat, snap, wsnap;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;

    // Reset values after two reset cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_writes0", 32'(writes0), 32'(0));
    chk("rst_reads10", 32'(reads10), 32'(0));
    chk("rst_out_port", 32'(out_port), 32'(0));
    chk("rst_tx_ready", 32'(tx_ready), 32'(1));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_rx_data", 32'({rx_err, rx_data}), 32'(0));
    chk("rst_err_cnt", 32'(err_cnt), 32'(0));
    rst = 1'b0;

    // Single TX byte: writes0 in the fourth cycle after the push cycle
    push_tx(8'hA5);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (writes0 && lat == 0) lat = k;
    end
    chk("tx_latency", 32'(lat), 32'(4));
    cyc(20);

    // Single RX byte announced by interrupt
    int_pct = 100;
    rx_mode = 1;
    inject_rx(8'h3C, 3'b000);
    drain(2000);
    cyc(20);

    // RX beats TX when both are ready in the same status read
    rx_mode = 1;
    snap = rd_data_cnt; wsnap = wr_cnt;
    chk("prio_tx_ready", 32'(tx_ready), 32'(1));
    tx_data = 8'h11; tx_valid = 1'b1;
    tx_exp.push_back(8'h11);
    inject_rx(8'h77, 3'b000);
    cyc(1);
    tx_valid = 1'b0;
    n = 0;
    while (wr_cnt == wsnap && n < 200) begin cyc(1); n++; end
    chk("prio_wr_seen", 32'(wr_cnt - wsnap), 32'(1));
    chk("prio_rd_first", 32'(rd_data_cnt - snap), 32'(1));
    drain(2000);
    cyc(20);

    // Full RX FIFO stalls data reads until a slot frees
    rx_mode = 0;
    snap = rd_data_cnt;
    for (int i = 0; i < DEPTH; i++) inject_rx(8'($urandom), 3'b000);
    inject_rx(8'($urandom), 3'b010);
    n = 0;
    while (rd_data_cnt - snap < DEPTH && n < 6000) begin cyc(1); n++; end
    chk("full_fill_reads", 32'(rd_data_cnt - snap), 32'(DEPTH));
    cyc(600);
    chk("full_no_read", 32'(rd_data_cnt - snap), 32'(DEPTH));
    chk("full_rx_valid", 32'(rx_valid), 32'(1));
    rx_mode = 2;
    cyc(1);
    rx_mode = 0;
    n = 0;
    while (rd_data_cnt - snap == DEPTH && n < 600) begin cyc(1); n++; end
    chk("full_resume", 32'(rd_data_cnt - snap), 32'(DEPTH + 1));
    rx_mode = 1;
    drain(4000);
    cyc(20);
    chk_err_cnt("err_cnt_after_full");

    // Reset while a write strobe is active
    push_tx(8'h5A);
    push_tx(8'h6B);
    push_tx(8'h7C);
    n = 0;
    @(negedge clk);
    while (!writes0 && n < 100) begin @(negedge clk); n++; end
    chk("rstmid_wr_seen", 32'(writes0), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_writes0", 32'(writes0), 32'(0));
    chk("rstmid_reads10", 32'(reads10), 32'(0));
    chk("rstmid_tx_ready", 32'(tx_ready), 32'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tx_exp.delete(); rx_exp.delete(); in_q.delete(); err_exp = 0;
    wsnap = wr_cnt;
    cyc(40);
    chk("rstmid_tx_discarded", 32'(wr_cnt - wsnap), 32'(0));
    chk_err_cnt("err_cnt_after_rst");

    // Mixed random traffic with random RX backpressure
    int_pct = 75;
    rx_mode = 1;
    for (int i = 0; i < 120; i++) begin
      case ($urandom % 4)
        0: push_tx(8'($urandom));
        1: begin
          inject_rx(8'($urandom), (($urandom % 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
          cyc(1);
        end
        default: cyc($urandom_range(1, 6));
      endcase
    end
    drain(30000);
    cyc(20);
    chk_err_cnt("err_cnt_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
